// File: rtl/sparserdes_node_k.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sparserdes_node_k : radix-FANOUT sparse serialiser/deserialiser tree node|
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sparserdes_node_k #(
  parameter int FANOUT = 4,
  parameter int LEAF   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FANOUT-1:0] nonempty_child,
  output logic              nonempty,
  input  logic              read,
  input  logic              write,
  input  logic              deserialized_bit,
  input  logic [FANOUT-1:0] serialized_bit_child,
  input  logic [FANOUT-1:0] done_child,
  output logic              serialized_bit,
  output logic [FANOUT-1:0] read_child,
  output logic [FANOUT-1:0] write_child,
  output logic              done,
  output logic              busy,
  output logic [FANOUT-1:0] mask_q
);
  localparam int IW = (FANOUT > 1) ? $clog2(FANOUT) : 1;
  localparam bit IS_LEAF = (LEAF != 0);
  localparam logic [IW-1:0] LAST = IW'(FANOUT - 1);
  localparam logic [FANOUT-1:0] ONE = FANOUT'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SMASK = 3'd1;
  localparam logic [2:0] S_SDESC = 3'd2;
  localparam logic [2:0] S_WMASK = 3'd3;
  localparam logic [2:0] S_WDESC = 3'd4;
  localparam logic [2:0] S_WLEAF = 3'd5;
  localparam logic [2:0] S_REFR  = 3'd6;

  logic [2:0]        state, state_n;
  logic [IW-1:0]     idx, idx_n, k, k_n;
  logic [FANOUT-1:0] mask_n, mask_cap, read_n, write_n;
  logic              sbit_n, done_n;
  logic [IW:0]       nxt, low_r, low_w;

  // {found, index} of the lowest set bit of m at or above position from
  function automatic logic [IW:0] first_set(input logic [FANOUT-1:0] m, input logic [IW:0] from);
    first_set = '0;
    for (int i = FANOUT - 1; i >= 0; i--)
      if (m[i] && (i >= int'(from))) first_set = {1'b1, IW'(i)};
  endfunction

  always_comb begin
    mask_cap      = mask_q;
    mask_cap[idx] = deserialized_bit;
  end

  assign nxt   = first_set(mask_q, {1'b0, k} + (IW+1)'(1));
  assign low_r = first_set(mask_q, '0);
  assign low_w = first_set(mask_cap, '0);
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      idx            <= '0;
      k              <= '0;
      mask_q         <= '0;
      serialized_bit <= 1'b0;
      done           <= 1'b0;
      read_child     <= '0;
      write_child    <= '0;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      k              <= k_n;
      mask_q         <= mask_n;
      serialized_bit <= sbit_n;
      done           <= done_n;
      read_child     <= read_n;
      write_child    <= write_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (read) state_n = S_SMASK; else if (write) state_n = S_WMASK;
      S_SMASK: if (idx == LAST) state_n = (IS_LEAF || !low_r[IW]) ? S_REFR : S_SDESC;
      S_SDESC: if (done_child[k] && !nxt[IW]) state_n = S_REFR;
      S_WMASK: if (idx == LAST) state_n = IS_LEAF ? S_WLEAF : (low_w[IW] ? S_WDESC : S_REFR);
      S_WDESC: if (done_child[k] && !nxt[IW]) state_n = S_REFR;
      S_WLEAF: state_n = S_REFR;
      S_REFR:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    idx_n   = idx;
    k_n     = k;
    mask_n  = mask_q;
    sbit_n  = 1'b0;
    done_n  = 1'b0;
    read_n  = read_child;
    write_n = write_child;
    case (state)
      S_IDLE: begin
        if (read) begin
          mask_n = nonempty_child;
          sbit_n = nonempty_child[0];
          idx_n  = IW'(1);
        end else if (write) begin
          mask_n[0] = deserialized_bit;
          idx_n     = IW'(1);
        end
      end
      S_SMASK: begin
        sbit_n = mask_q[idx];
        idx_n  = idx + IW'(1);
        if (idx == LAST) begin
          idx_n = '0;
          if (IS_LEAF || !low_r[IW]) done_n = 1'b1;
          else begin
            k_n    = low_r[IW-1:0];
            read_n = ONE << low_r[IW-1:0];
          end
        end
      end
      S_SDESC: begin
        sbit_n = serialized_bit_child[k];
        if (done_child[k]) begin
          if (nxt[IW]) begin
            k_n    = nxt[IW-1:0];
            read_n = ONE << nxt[IW-1:0];
          end else begin
            read_n = '0;
            done_n = 1'b1;
          end
        end
      end
      S_WMASK: begin
        mask_n = mask_cap;
        idx_n  = idx + IW'(1);
        if (idx == LAST) begin
          idx_n = '0;
          if (!IS_LEAF) begin
            if (!low_w[IW]) done_n = 1'b1;
            else begin
              k_n     = low_w[IW-1:0];
              write_n = ONE << low_w[IW-1:0];
            end
          end
        end
      end
      S_WDESC: begin
        if (done_child[k]) begin
          if (nxt[IW]) begin
            k_n     = nxt[IW-1:0];
            write_n = ONE << nxt[IW-1:0];
          end else begin
            write_n = '0;
            done_n  = 1'b1;
          end
        end
      end
      S_WLEAF: begin
        write_n = mask_q;
        done_n  = 1'b1;
      end
      S_REFR: begin
        read_n  = '0;
        write_n = '0;
      end
      default: ;
    endcase
  end

  // Leaves report occupancy combinationally; interior nodes register it
  generate
    if (IS_LEAF) begin : g_leaf_nonempty
      assign nonempty = |nonempty_child;
    end else begin : g_reg_nonempty
      logic nonempty_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) nonempty_q <= 1'b0;
        else       nonempty_q <= |nonempty_child;
      end
      assign nonempty = nonempty_q;
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_sparserdes_node_k.sv
`default_nettype none
// Bench for sparserdes_node_k: an interior and a leaf instance (FANOUT=4)
// driven with directed and random transfers against a trace-level model.
module tb_sparserdes_node_k;
  localparam int F = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [F-1:0] nec_i, sbc_i, dc_i, rc_i, wc_i, mq_i;
  logic rd_i, wr_i, db_i, ne_i, sb_i, dn_i, bz_i;
  logic [F-1:0] nec_l, sbc_l, dc_l, rc_l, wc_l, mq_l;
  logic rd_l, wr_l, db_l, ne_l, sb_l, dn_l, bz_l;

  sparserdes_node_k #(.FANOUT(F), .LEAF(0)) dut_i (
    .clk(clk), .reset(reset), .nonempty_child(nec_i), .nonempty(ne_i),
    .read(rd_i), .write(wr_i), .deserialized_bit(db_i),
    .serialized_bit_child(sbc_i), .done_child(dc_i), .serialized_bit(sb_i),
    .read_child(rc_i), .write_child(wc_i), .done(dn_i), .busy(bz_i), .mask_q(mq_i));

  sparserdes_node_k #(.FANOUT(F), .LEAF(1)) dut_l (
    .clk(clk), .reset(reset), .nonempty_child(nec_l), .nonempty(ne_l),
    .read(rd_l), .write(wr_l), .deserialized_bit(db_l),
    .serialized_bit_child(sbc_l), .done_child(dc_l), .serialized_bit(sb_l),
    .read_child(rc_l), .write_child(wc_l), .done(dn_l), .busy(bz_l), .mask_q(mq_l));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [F-1:0] oh(input int c);
    oh = '0;
    oh[c] = 1'b1;
  endfunction

  // Model state: per-child visit durations/bits and the expected per-cycle trace
  int dur[F];
  logic [15:0] bits[F];
  int cnt[F];
  logic [F-1:0] e_sel[$];
  logic e_sb[$], e_dn[$];

  // Spec-level trace: F mask cycles, then each occupied child (ascending)
  // is selected for its duration; its bits come out one cycle later.
  task automatic build_model(input logic [F-1:0] m, input logic [15:0] durs);
    int sq[$];
    logic bq[$];
    e_sel.delete(); e_sb.delete(); e_dn.delete();
    for (int c = 0; c < F; c++) begin
      dur[c]  = (durs[4*c +: 4] == 4'd0) ? int'($urandom_range(1, 4)) : int'(durs[4*c +: 4]);
      bits[c] = 16'($urandom);
      cnt[c]  = 0;
      if (m[c]) for (int j = 0; j < dur[c]; j++) begin sq.push_back(c); bq.push_back(bits[c][j]); end
    end
    for (int i = 0; i < F; i++) begin e_sb.push_back(m[i]); e_sel.push_back('0); e_dn.push_back(1'b0); end
    if (sq.size() == 0) e_dn[F-1] = 1'b1;
    else begin
      e_sel[F-1] = oh(sq[0]);
      for (int j = 1; j < sq.size(); j++) begin
        e_sb.push_back(bq[j-1]); e_sel.push_back(oh(sq[j])); e_dn.push_back(1'b0);
      end
      e_sb.push_back(bq[sq.size()-1]); e_sel.push_back('0); e_dn.push_back(1'b1);
    end
    e_sb.push_back(1'b0); e_sel.push_back('0); e_dn.push_back(1'b0);
  endtask

  // Child stub: the selected child streams its bits and raises done on its
  // last cycle; unselected children drive noise that must be ignored.
  task automatic drive_children(input logic [F-1:0] sel);
    for (int c = 0; c < F; c++) begin
      if (sel[c] && cnt[c] < dur[c]) begin
        sbc_i[c] = bits[c][cnt[c]];
        dc_i[c]  = (cnt[c] == dur[c] - 1);
        cnt[c]++;
      end else begin
        sbc_i[c] = 1'($urandom);
        dc_i[c]  = sel[c] ? 1'b0 : 1'($urandom);
      end
    end
  endtask

  task automatic read_i(input logic [F-1:0] m, input bit also_write, input int abort_at,
                        input logic [15:0] durs);
    build_model(m, durs);
    @(negedge clk);
    nec_i = m; rd_i = 1'b1; wr_i = also_write; db_i = 1'($urandom);
    for (int t = 0; t < e_sb.size(); t++) begin
      @(negedge clk);
      rd_i = 1'b0; wr_i = 1'b0;
      if (abort_at > 0 && t == abort_at) return;
      check($sformatf("rd_i sbit t=%0d", t), 32'(sb_i), 32'(e_sb[t]));
      check($sformatf("rd_i read_child t=%0d", t), 32'(rc_i), 32'(e_sel[t]));
      check($sformatf("rd_i done t=%0d", t), 32'(dn_i), 32'(e_dn[t]));
      check($sformatf("rd_i busy t=%0d", t), 32'(bz_i), 32'(t < e_sb.size() - 1));
      check($sformatf("rd_i write_child t=%0d", t), 32'(wc_i), 32'(0));
      if (t < F - 1) nec_i = F'($urandom);
      drive_children(rc_i);
    end
    sbc_i = '0; dc_i = '0;
    check("rd_i mask_q", 32'(mq_i), 32'(m));
  endtask

  task automatic write_i(input logic [F-1:0] m, input logic [15:0] durs);
    build_model(m, durs);
    @(negedge clk);
    wr_i = 1'b1; db_i = m[0];
    for (int t = 0; t < e_sel.size(); t++) begin
      @(negedge clk);
      wr_i = 1'b0;
      db_i = (t + 1 < F) ? m[t+1] : 1'($urandom);
      check($sformatf("wr_i write_child t=%0d", t), 32'(wc_i), 32'(e_sel[t]));
      check($sformatf("wr_i done t=%0d", t), 32'(dn_i), 32'(e_dn[t]));
      check($sformatf("wr_i busy t=%0d", t), 32'(bz_i), 32'(t < e_sel.size() - 1));
      check($sformatf("wr_i read_child t=%0d", t), 32'(rc_i), 32'(0));
      check($sformatf("wr_i sbit t=%0d", t), 32'(sb_i), 32'(0));
      drive_children(wc_i);
    end
    sbc_i = '0; dc_i = '0;
    check("wr_i mask_q", 32'(mq_i), 32'(m));
  endtask

  task automatic read_l(input logic [F-1:0] m);
    @(negedge clk);
    nec_l = m; rd_l = 1'b1;
    for (int t = 0; t <= F; t++) begin
      @(negedge clk);
      rd_l = 1'b0;
      check($sformatf("rd_l sbit t=%0d", t), 32'(sb_l), 32'((t < F) ? m[t] : 1'b0));
      check($sformatf("rd_l done t=%0d", t), 32'(dn_l), 32'(t == F - 1));
      check($sformatf("rd_l busy t=%0d", t), 32'(bz_l), 32'(t < F));
      check($sformatf("rd_l read_child t=%0d", t), 32'(rc_l), 32'(0));
      if (t < F - 1) nec_l = F'($urandom);
      #1 check($sformatf("rd_l nonempty t=%0d", t), 32'(ne_l), 32'(|nec_l));
    end
    check("rd_l mask_q", 32'(mq_l), 32'(m));
  endtask

  task automatic write_l(input logic [F-1:0] m);
    @(negedge clk);
    wr_l = 1'b1; db_l = m[0];
    for (int t = 0; t <= F + 1; t++) begin
      @(negedge clk);
      wr_l = 1'b0;
      db_l = (t + 1 < F) ? m[t+1] : 1'($urandom);
      check($sformatf("wr_l write_child t=%0d", t), 32'(wc_l), 32'((t == F) ? m : '0));
      check($sformatf("wr_l done t=%0d", t), 32'(dn_l), 32'(t == F));
      check($sformatf("wr_l busy t=%0d", t), 32'(bz_l), 32'(t <= F));
    end
    check("wr_l mask_q", 32'(mq_l), 32'(m));
  endtask

  initial begin
    reset = 1'b1;
    nec_i = '0; sbc_i = '0; dc_i = '0; rd_i = 1'b0; wr_i = 1'b0; db_i = 1'b0;
    nec_l = '0; sbc_l = '0; dc_l = '0; rd_l = 1'b0; wr_l = 1'b0; db_l = 1'b0;
    repeat (2) @(negedge clk);
    check("rst sbit", 32'(sb_i), 32'(0));
    check("rst done", 32'(dn_i), 32'(0));
    check("rst busy", 32'(bz_i), 32'(0));
    check("rst read_child", 32'(rc_i), 32'(0));
    check("rst write_child", 32'(wc_i), 32'(0));
    check("rst mask_q", 32'(mq_i), 32'(0));
    check("rst nonempty", 32'(ne_i), 32'(0));
    check("rst leaf busy", 32'(bz_l), 32'(0));
    reset = 1'b0;

    // Occupancy flag: registered on the interior node, combinational on the leaf
    @(negedge clk);
    nec_i = 4'b0100; nec_l = 4'b1010;
    #1 check("ne_i before edge", 32'(ne_i), 32'(0));
    check("ne_l comb", 32'(ne_l), 32'(1));
    @(negedge clk);
    check("ne_i after edge", 32'(ne_i), 32'(1));
    nec_l = '0;
    #1 check("ne_l comb clear", 32'(ne_l), 32'(0));

    read_l(4'b1010);
    write_l(4'b0110);
    read_i(4'b0101, 1'b0, 0, 16'h0203);
    write_i(4'b0011, 16'h0000);
    read_i(4'b1011, 1'b1, 0, 16'h0000);
    read_i(4'b0000, 1'b0, 0, 16'h0000);
    write_i(4'b0000, 16'h0000);
    write_i(4'b1000, 16'h3000);
    for (int r = 0; r < 6; r++) begin
      read_i(F'($urandom), 1'(r), 0, 16'h0000);
      write_i(F'($urandom), 16'h0000);
      read_l(F'($urandom));
      write_l(F'($urandom));
    end

    // Asynchronous reset between edges while child 3 is being read
    read_i(4'b1000, 1'b0, 7, 16'hF000);
    #2 reset = 1'b1;
    #1;
    check("arst read_child", 32'(rc_i), 32'(0));
    check("arst done", 32'(dn_i), 32'(0));
    check("arst sbit", 32'(sb_i), 32'(0));
    check("arst busy", 32'(bz_i), 32'(0));
    check("arst mask_q", 32'(mq_i), 32'(0));
    sbc_i = '0; dc_i = '0;
    @(negedge clk);
    reset = 1'b0;
    read_i(4'b0110, 1'b0, 0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sparserdes_node_k.md
Name: sparserdes_node_k

Overview:
- Radix-K generalisation of the sparse serialiser/deserialiser tree node, with FANOUT children instead of two.
- Serialisation: on read, emits the full FANOUT-bit child-occupancy mask, LSB first, then descends in ascending index order into each occupied child, forwarding that child's bitstream.
- Deserialisation: on write, captures a FANOUT-bit mask from the parent, then drives writes into the flagged children.
- Instantiated recursively to build K-ary sparse event trees; LEAF instances terminate the tree.

Parameters:
- FANOUT, 4, number of children (>=2); IW=$clog2(FANOUT) is the index/counter width.
- LEAF, 0, 1 = leaf node (no descent; combinational nonempty; parallel write strobe).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- nonempty_child  in  FANOUT  per-child nonempty flag.
- nonempty  out  1  OR of nonempty_child; combinational if LEAF, registered otherwise.
- read  in  1  parent requests serialisation.
- write  in  1  parent requests deserialisation.
- deserialized_bit  in  1  mask bit from the parent.
- serialized_bit_child  in  FANOUT  serial bit from each child.
- done_child  in  FANOUT  child finished flag.
- serialized_bit  out  1  serial bit to the parent (registered).
- read_child  out  FANOUT  one-hot read request to a child.
- write_child  out  FANOUT  write request to children.
- done  out  1  one-cycle finished pulse to the parent.
- busy  out  1  high whenever state != IDLE.
- mask_q  out  FANOUT  last captured or snapshotted mask.

Behaviour:
- Reset (async): all outputs and state return to 0 immediately, including mid-transfer. State=IDLE, idx=0, mask_q=0.
- States: IDLE, SMASK, SDESC, WMASK, WDESC, WLEAF, REFR.

IDLE:
- serialized_bit<=0, done<=0.
- read=1: mask_q<=nonempty_child (snapshot), serialized_bit<=nonempty_child[0], idx<=1, go to SMASK.
- write=1 (and read=0): mask_q[0]<=deserialized_bit, idx<=1, go to WMASK.
- read and write both high: read wins.

SMASK:
- Each cycle serialized_bit<=mask_q[idx], idx++.
- On the cycle emitting bit FANOUT-1, if LEAF or mask_q==0: done<=1 in the same cycle, go to REFR.
- Otherwise go to SDESC with k = lowest set bit of mask_q, and read_child<=onehot(k).

SDESC:
- serialized_bit<=serialized_bit_child[k] (1-cycle registered pass-through).
- read_child[k] is held until done_child[k].
- On done_child[k]: if a higher set bit k' exists, read_child<=onehot(k') and continue.
- Otherwise read_child<=0, done<=1, go to REFR.
- done_child for non-selected children is ignored.

WMASK:
- Each cycle mask_q[idx]<=deserialized_bit, idx++.
- After bit FANOUT-1 is captured:
  - LEAF: go to WLEAF.
  - Interior, mask zero: done<=1, go to REFR.
  - Interior, mask nonzero: write_child<=onehot(lowest set bit), go to WDESC.
- Per-bit timing: bit i is sampled i cycles after the write cycle.

WLEAF:
- write_child<=mask_q for exactly one cycle, done<=1 in the same cycle, go to REFR.

WDESC:
- Same walk as SDESC, using write_child and done_child; no serial forwarding.

REFR:
- One cycle: done<=0, serialized_bit<=0, read_child<=0, write_child<=0, go to IDLE.
- read/write seen in REFR is ignored; the parent must deassert before the next IDLE cycle.

General:
- Snapshot: nonempty_child changes during SMASK/SDESC do not alter the mask or walk order.
- Read/write are level requests sampled only in IDLE.
- Latency:
  - Leaf read: done asserts FANOUT cycles after read.
  - Interior read: FANOUT mask cycles plus the sum of the visited children's durations.
- busy=0 only in IDLE.

Test Plan:
- FANOUT=4, LEAF=1, nonempty_child=4'b1010, read pulse -> serialized_bit 0,1,0,1 on the next 4 cycles; done high with the 4th bit; busy low 2 cycles after done; mask_q=4'b1010.
- FANOUT=4, LEAF=0, mask 4'b0101, child0 done after 3 cycles, child2 done after 2 cycles -> mask bits 1,0,1,0; read_child=0001 then 0100; child bits forwarded with 1-cycle delay; single done pulse; nonempty=1.
- FANOUT=4, LEAF=0, deserialized bits 1,1,0,0 from the write cycle -> mask_q=4'b0011; write_child 0001 until done_child[0], then 0010 until done_child[1]; then done.
- FANOUT=4, LEAF=1, write mask bits 0,1,1,0 -> write_child=4'b0110 for exactly one cycle, with done in the same cycle.
- Interior, read and write asserted together in IDLE -> serialisation path taken, write_child stays 0; nonempty_child toggled mid-SMASK -> emitted mask unchanged.
- Reset asserted mid-SDESC (async, between clock edges) -> read_child, done, serialized_bit, busy, and mask_q all 0 immediately; a subsequent read restarts at mask bit 0.
